// File: rtl/peri_pkg.sv
// ---------------------------------------------------------------------------
// peri_pkg
// Shared definitions for the peripheral timer / interrupt controller:
//   - default bus window base address
//   - register word indices (peri_addr[7:2])
//   - CTRL bit positions
//   - byte-enable helpers used by every RW register
// ---------------------------------------------------------------------------
package peri_pkg;

  // Default window base. The top compares peri_addr[31:8] against it, so
  // with this default the block answers in 0x1000_0000..0x1000_00FF.
  localparam logic [31:0] PERI_BASE_ADDR = 32'h1000_0000;

  // Register word indices (byte offset >> 2).
  localparam logic [5:0] OFF_MTIME    = 6'h00;  // 0x00
  localparam logic [5:0] OFF_MTIMECMP = 6'h01;  // 0x04
  localparam logic [5:0] OFF_CTRL     = 6'h02;  // 0x08
  localparam logic [5:0] OFF_PENDING  = 6'h03;  // 0x0C
  localparam logic [5:0] OFF_MASK     = 6'h04;  // 0x10
  localparam logic [5:0] OFF_EXT_RAW  = 6'h05;  // 0x14

  // CTRL bit positions.
  localparam int CTRL_EN          = 0;
  localparam int CTRL_AUTO_RELOAD = 1;

  // Expand 4 byte enables into a 32-bit bit mask.
  function automatic logic [31:0] strb_to_mask(input logic [3:0] strb);
    strb_to_mask = {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
  endfunction

  // Replace only the enabled bytes of old_val with new_val.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  strb);
    logic [31:0] m;
    m = strb_to_mask(strb);
    merge_bytes = (old_val & ~m) | (new_val & m);
  endfunction

endpackage

// File: rtl/irq_ctrl.sv
// ---------------------------------------------------------------------------
// irq_ctrl
// Interrupt collection: rising-edge detect on external sources, the PENDING
// (W1C, set wins over clear) and MASK registers, and registered irq_bitmap.
//   clk, resetn   : clock, asynchronous active-low reset
//   timer_set     : timer compare match this cycle -> PENDING[0]
//   ext_irq       : level sources -> PENDING[EXT_IRQ_W:1] on rising edge
//   pend_wr       : bus write to PENDING this cycle (W1C)
//   mask_wr       : bus write to MASK this cycle
//   wdata, wstrb  : bus write data and byte enables
//   pending, mask : current register values (for bus reads)
//   irq_bitmap    : registered pending & mask
// ---------------------------------------------------------------------------
module irq_ctrl
  import peri_pkg::*;
#(
  parameter int EXT_IRQ_W = 31
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 timer_set,
  input  logic [EXT_IRQ_W-1:0] ext_irq,
  input  logic                 pend_wr,
  input  logic                 mask_wr,
  input  logic [31:0]          wdata,
  input  logic [3:0]           wstrb,
  output logic [31:0]          pending,
  output logic [31:0]          mask,
  output logic [31:0]          irq_bitmap
);

  logic [EXT_IRQ_W-1:0] ext_prev_reg;
  logic [31:0]          pending_reg;
  logic [31:0]          pending_next;
  logic [31:0]          mask_reg;
  logic [31:0]          irq_bitmap_reg;
  logic [31:0]          clr_vec;

  // W1C only touches bits that are both written as 1 and in enabled bytes.
  assign clr_vec = pend_wr ? (wdata & strb_to_mask(wstrb)) : 32'h0;

  // Per-bit next-state: a set event in the same cycle as a clear wins.
  // Bits above EXT_IRQ_W have no source and stay 0.
  genvar gi;
  generate
    for (gi = 0; gi < 32; gi++) begin : g_pend
      if (gi == 0) begin : g_timer
        assign pending_next[gi] = timer_set | (pending_reg[gi] & ~clr_vec[gi]);
      end else if (gi <= EXT_IRQ_W) begin : g_ext
        assign pending_next[gi] = (ext_irq[gi-1] & ~ext_prev_reg[gi-1]) |
                                  (pending_reg[gi] & ~clr_vec[gi]);
      end else begin : g_tied
        assign pending_next[gi] = 1'b0;
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ext_prev_reg   <= '0;
      pending_reg    <= '0;
      mask_reg       <= '0;
      irq_bitmap_reg <= '0;
    end else begin
      ext_prev_reg <= ext_irq;
      pending_reg  <= pending_next;
      if (mask_wr) begin
        mask_reg <= merge_bytes(mask_reg, wdata, wstrb);
      end
      // Uses pending_next so a newly set bit shows up together with PENDING;
      // uses mask_reg so a MASK write lands one cycle after it is visible.
      irq_bitmap_reg <= pending_next & mask_reg;
    end
  end

  assign pending    = pending_reg;
  assign mask       = mask_reg;
  assign irq_bitmap = irq_bitmap_reg;

endmodule

// File: rtl/peri_timer_irq.sv
// ---------------------------------------------------------------------------
// peri_timer_irq
// Memory-mapped 32-bit compare timer plus interrupt controller.
//   clk, resetn          : clock, asynchronous active-low reset
//   peri_rden/peri_wren  : single-cycle read / write request pulses
//   peri_addr            : byte address; [31:8] window, [7:2] register
//   peri_wdata/peri_wstrb: write data and byte enables
//   peri_rdata           : read data, non-zero only with peri_ready
//   peri_ready           : one-cycle completion, one cycle after request
//   ext_irq              : external level interrupt sources
//   irq_bitmap           : registered pending & mask
// ---------------------------------------------------------------------------
module peri_timer_irq
  import peri_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = PERI_BASE_ADDR,
  parameter int          EXT_IRQ_W = 31
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 peri_rden,
  input  logic                 peri_wren,
  input  logic [31:0]          peri_addr,
  input  logic [31:0]          peri_wdata,
  input  logic [3:0]           peri_wstrb,
  output logic [31:0]          peri_rdata,
  output logic                 peri_ready,
  input  logic [EXT_IRQ_W-1:0] ext_irq,
  output logic [31:0]          irq_bitmap
);

  logic        in_window, rd_hit, wr_hit;
  logic [5:0]  reg_sel;
  logic        wr_mtime, wr_mtimecmp, wr_ctrl, wr_pending, wr_mask;
  logic [31:0] mtime_reg, mtime_next, mtimecmp_reg;
  logic        ctrl_en_reg, ctrl_ar_reg;
  logic        timer_match;
  logic [31:0] ctrl_word, ext_raw, pending, mask;
  logic [31:0] rdata_next, rdata_reg;
  logic        ready_reg;
  logic [1:0]  unused_addr_lsb;

  assign unused_addr_lsb = peri_addr[1:0];

  // Bus decode
  assign in_window = (peri_addr[31:8] == BASE_ADDR[31:8]);
  assign rd_hit    = peri_rden & in_window;
  assign wr_hit    = peri_wren & in_window;
  assign reg_sel   = peri_addr[7:2];

  assign wr_mtime    = wr_hit && (reg_sel == OFF_MTIME);
  assign wr_mtimecmp = wr_hit && (reg_sel == OFF_MTIMECMP);
  assign wr_ctrl     = wr_hit && (reg_sel == OFF_CTRL);
  assign wr_pending  = wr_hit && (reg_sel == OFF_PENDING);
  assign wr_mask     = wr_hit && (reg_sel == OFF_MASK);

  // Timer: compare only while enabled; a bus write beats count/reload.
  assign timer_match = ctrl_en_reg && (mtime_reg == mtimecmp_reg);

  always_comb begin
    mtime_next = mtime_reg;
    if (wr_mtime) begin
      mtime_next = merge_bytes(mtime_reg, peri_wdata, peri_wstrb);
    end else if (ctrl_en_reg) begin
      mtime_next = (ctrl_ar_reg && timer_match) ? 32'h0 : mtime_reg + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mtime_reg    <= '0;
      mtimecmp_reg <= 32'hFFFF_FFFF;
      ctrl_en_reg  <= 1'b0;
      ctrl_ar_reg  <= 1'b0;
    end else begin
      mtime_reg <= mtime_next;
      if (wr_mtimecmp) begin
        mtimecmp_reg <= merge_bytes(mtimecmp_reg, peri_wdata, peri_wstrb);
      end
      // Both CTRL bits live in byte 0.
      if (wr_ctrl && peri_wstrb[0]) begin
        ctrl_en_reg <= peri_wdata[CTRL_EN];
        ctrl_ar_reg <= peri_wdata[CTRL_AUTO_RELOAD];
      end
    end
  end

  // Read mux
  always_comb begin
    ctrl_word                   = '0;
    ctrl_word[CTRL_EN]          = ctrl_en_reg;
    ctrl_word[CTRL_AUTO_RELOAD] = ctrl_ar_reg;
  end

  always_comb begin
    ext_raw              = '0;
    ext_raw[EXT_IRQ_W:1] = ext_irq;
  end

  always_comb begin
    rdata_next = '0;
    if (rd_hit) begin
      case (reg_sel)
        OFF_MTIME:    rdata_next = mtime_reg;
        OFF_MTIMECMP: rdata_next = mtimecmp_reg;
        OFF_CTRL:     rdata_next = ctrl_word;
        OFF_PENDING:  rdata_next = pending;
        OFF_MASK:     rdata_next = mask;
        OFF_EXT_RAW:  rdata_next = ext_raw;
        default:      rdata_next = '0;
      endcase
    end
  end

  // Response pipeline: every in-window request, mapped or not, is answered.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ready_reg <= 1'b0;
      rdata_reg <= '0;
    end else begin
      ready_reg <= rd_hit | wr_hit;
      rdata_reg <= rdata_next;
    end
  end

  assign peri_ready = ready_reg;
  assign peri_rdata = rdata_reg;

  irq_ctrl #(
    .EXT_IRQ_W (EXT_IRQ_W)
  ) u_irq_ctrl (
    .clk        (clk),
    .resetn     (resetn),
    .timer_set  (timer_match),
    .ext_irq    (ext_irq),
    .pend_wr    (wr_pending),
    .mask_wr    (wr_mask),
    .wdata      (peri_wdata),
    .wstrb      (peri_wstrb),
    .pending    (pending),
    .mask       (mask),
    .irq_bitmap (irq_bitmap)
  );

endmodule

// File: tb/tb_peri_timer_irq.sv
// ---------------------------------------------------------------------------
// tb_peri_timer_irq
// Directed stimulus with a scoreboard: each accepted request pushes its
// expected read data and the cycle its ready must appear; a negedge monitor
// pops on peri_ready and compares. irq_bitmap is checked directly.
// ---------------------------------------------------------------------------
module tb_peri_timer_irq;

  localparam int          EXT_W = 31;
  localparam logic [31:0] B     = 32'h1000_0000;
  localparam logic [31:0] A_MTIME = B + 32'h00;
  localparam logic [31:0] A_CMP   = B + 32'h04;
  localparam logic [31:0] A_CTRL  = B + 32'h08;
  localparam logic [31:0] A_PEND  = B + 32'h0C;
  localparam logic [31:0] A_MASK  = B + 32'h10;
  localparam logic [31:0] A_RAW   = B + 32'h14;
  localparam logic [31:0] A_UNMAP = B + 32'h18;

  logic             clk = 1'b0;
  logic             resetn = 1'b0;
  logic             peri_rden = 1'b0;
  logic             peri_wren = 1'b0;
  logic [31:0]      peri_addr = '0;
  logic [31:0]      peri_wdata = '0;
  logic [3:0]       peri_wstrb = '0;
  logic [31:0]      peri_rdata;
  logic             peri_ready;
  logic [EXT_W-1:0] ext_irq = '0;
  logic [31:0]      irq_bitmap;

  typedef struct {
    logic [31:0] data;
    int          due;
    string       name;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;

  peri_timer_irq #(
    .BASE_ADDR (B),
    .EXT_IRQ_W (EXT_W)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .peri_rden  (peri_rden),
    .peri_wren  (peri_wren),
    .peri_addr  (peri_addr),
    .peri_wdata (peri_wdata),
    .peri_wstrb (peri_wstrb),
    .peri_rdata (peri_rdata),
    .peri_ready (peri_ready),
    .ext_irq    (ext_irq),
    .irq_bitmap (irq_bitmap)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Tasks are entered 1 time unit after a rising edge and return at the
  // same phase one cycle later, so consecutive calls issue back-to-back.
  task automatic bus_rd(input logic [31:0] addr, input logic [31:0] exp,
                        input bit rsp, input string name);
    exp_t e;
    peri_rden = 1'b1;
    peri_addr = addr;
    if (rsp) begin
      e.data = exp; e.due = cyc + 1; e.name = name;
      sb_q.push_back(e);
    end
    @(posedge clk); #1;
    peri_rden = 1'b0;
  endtask

  task automatic bus_wr(input logic [31:0] addr, input logic [31:0] data,
                        input logic [3:0] strb, input bit rsp, input string name);
    exp_t e;
    peri_wren  = 1'b1;
    peri_addr  = addr;
    peri_wdata = data;
    peri_wstrb = strb;
    if (rsp) begin
      e.data = 32'h0; e.due = cyc + 1; e.name = name;
      sb_q.push_back(e);
    end
    @(posedge clk); #1;
    peri_wren = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("[TB] ok   %s = %h", name, act);
    end
  endtask

  // Monitor: one line per completed bus transaction.
  always @(negedge clk) begin
    if (resetn) begin
      if (peri_ready) begin
        tests++;
        if (sb_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_ready: rdata %h at cycle %0d, none expected", peri_rdata, cyc);
        end else begin
          mon_e = sb_q.pop_front();
          if (peri_rdata !== mon_e.data || cyc != mon_e.due) begin
            fails++;
            $display("FAIL %s: got %h at cycle %0d expected %h at cycle %0d",
                     mon_e.name, peri_rdata, cyc, mon_e.data, mon_e.due);
          end else begin
            $display("[TB] ok   %s rdata=%h cycle=%0d", mon_e.name, peri_rdata, cyc);
          end
        end
      end else begin
        if (peri_rdata !== 32'h0) begin
          tests++;
          fails++;
          $display("FAIL rdata_idle: got %h expected 00000000", peri_rdata);
        end
        if (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
          tests++;
          fails++;
          mon_e = sb_q.pop_front();
          $display("FAIL %s: no ready at cycle %0d expected ready with %h",
                   mon_e.name, cyc, mon_e.data);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
    check("rst_irq_bitmap", irq_bitmap, 32'h0);
    check("rst_ready", {31'h0, peri_ready}, 32'h0);
    check("rst_rdata", peri_rdata, 32'h0);

    // Reset values of every offset, back to back
    bus_rd(A_MTIME, 32'h0,          1, "rst_mtime");
    bus_rd(A_CMP,   32'hFFFF_FFFF,  1, "rst_mtimecmp");
    bus_rd(A_CTRL,  32'h0,          1, "rst_ctrl");
    bus_rd(A_PEND,  32'h0,          1, "rst_pending");
    bus_rd(A_MASK,  32'h0,          1, "rst_mask");
    bus_rd(A_RAW,   32'h0,          1, "rst_ext_raw");
    bus_rd(A_UNMAP, 32'h0,          1, "unmapped_rd");

    // Compare match: CMP=10, MASK=1, EN at cycle T
    bus_wr(A_CMP,  32'd10, 4'hF, 1, "wr_cmp10");
    bus_wr(A_MASK, 32'd1,  4'hF, 1, "wr_mask1");
    bus_wr(A_CTRL, 32'd1,  4'hF, 1, "wr_ctrl_en");
    bus_rd(A_MTIME, 32'd0, 1, "mtime_t1");
    bus_rd(A_MTIME, 32'd1, 1, "mtime_t2");
    idle(7);
    bus_rd(A_PEND, 32'h0, 1, "pend_before_match");
    check("bitmap_before_match", irq_bitmap, 32'h0);
    bus_rd(A_PEND, 32'h0, 1, "pend_in_match");
    check("bitmap_after_match", irq_bitmap, 32'h1);
    bus_rd(A_PEND, 32'h1, 1, "pend_after_match");
    bus_wr(A_PEND, 32'h1, 4'hF, 1, "w1c_pend0");
    check("bitmap_after_w1c", irq_bitmap, 32'h0);
    bus_rd(A_PEND, 32'h0, 1, "pend_after_w1c");
    bus_wr(A_CTRL, 32'h0, 4'hF, 1, "wr_ctrl_off");

    // Auto-reload with CMP=3
    bus_wr(A_MTIME, 32'h0, 4'hF, 1, "wr_mtime0");
    bus_wr(A_CMP,   32'd3, 4'hF, 1, "wr_cmp3");
    bus_wr(A_CTRL,  32'd3, 4'hF, 1, "wr_ctrl_en_ar");
    bus_rd(A_MTIME, 32'd0, 1, "ar_mtime_0");
    bus_rd(A_MTIME, 32'd1, 1, "ar_mtime_1");
    bus_rd(A_MTIME, 32'd2, 1, "ar_mtime_2");
    bus_rd(A_MTIME, 32'd3, 1, "ar_mtime_3");
    bus_rd(A_MTIME, 32'd0, 1, "ar_mtime_reload");
    bus_rd(A_MTIME, 32'd1, 1, "ar_mtime_1b");
    bus_rd(A_PEND,  32'h1, 1, "ar_pend_set");
    bus_wr(A_PEND,  32'h1, 4'hF, 1, "ar_w1c_in_match");
    bus_rd(A_PEND,  32'h1, 1, "ar_set_wins");
    check("ar_bitmap", irq_bitmap, 32'h1);
    bus_wr(A_PEND,  32'h1, 4'hF, 1, "ar_w1c_idle");
    bus_rd(A_PEND,  32'h0, 1, "ar_pend_cleared");
    bus_rd(A_MTIME, 32'd3, 1, "ar_mtime_3b");
    bus_rd(A_PEND,  32'h1, 1, "ar_pend_reset");
    bus_wr(A_CTRL,  32'h0, 4'hF, 1, "ar_ctrl_off");
    bus_wr(A_PEND,  32'h1, 4'hF, 1, "ar_w1c_final");
    bus_rd(A_PEND,  32'h0, 1, "ar_pend_final");

    // Wrap-around
    bus_wr(A_MTIME, 32'hFFFF_FFFE, 4'hF, 1, "wr_mtime_fffe");
    bus_wr(A_CTRL,  32'd1, 4'hF, 1, "wrap_en");
    bus_rd(A_MTIME, 32'hFFFF_FFFE, 1, "wrap_fffe");
    bus_rd(A_MTIME, 32'hFFFF_FFFF, 1, "wrap_ffff");
    bus_rd(A_MTIME, 32'h0, 1, "wrap_0");
    bus_rd(A_MTIME, 32'h1, 1, "wrap_1");
    bus_wr(A_CTRL,  32'h0, 4'hF, 1, "wrap_off");
    bus_rd(A_CTRL,  32'h0, 1, "ctrl_off_rd");

    // Byte-lane write to MASK
    bus_wr(A_MASK, 32'h0000_AB00, 4'b0010, 1, "mask_byte1");
    bus_rd(A_MASK, 32'h0000_AB01, 1, "mask_byte1_rd");
    bus_wr(A_MASK, 32'h0000_0001, 4'hF, 1, "mask_restore");

    // External rising edge on ext_irq[4] -> PENDING[5]
    ext_irq[4] = 1'b1;
    bus_rd(A_RAW,  32'h20, 1, "ext_raw_bit4");
    bus_rd(A_PEND, 32'h20, 1, "ext_pend_set");
    bus_wr(A_PEND, 32'h20, 4'b0010, 1, "ext_w1c_wrong_lane");
    bus_rd(A_PEND, 32'h20, 1, "ext_pend_kept");
    bus_wr(A_PEND, 32'h20, 4'b0001, 1, "ext_w1c");
    bus_rd(A_PEND, 32'h0, 1, "ext_no_rearm_high");
    check("ext_bitmap_masked", irq_bitmap, 32'h0);
    ext_irq[4] = 1'b0;
    idle(2);
    bus_rd(A_PEND, 32'h0, 1, "ext_fall_no_set");
    ext_irq[4] = 1'b1;
    idle(1);
    bus_rd(A_PEND, 32'h20, 1, "ext_rearm");
    check("ext_bitmap_masked2", irq_bitmap, 32'h0);
    bus_wr(A_PEND, 32'h20, 4'hF, 1, "ext_clear");

    // Outside-window requests and unmapped writes
    bus_rd(32'h1000_1000, 32'h0, 0, "outside_rd");
    bus_wr(32'h1000_1010, 32'hFFFF_FFFF, 4'hF, 0, "outside_wr");
    bus_rd(A_MASK, 32'h1, 1, "mask_after_outside");
    bus_wr(A_UNMAP, 32'hFFFF_FFFF, 4'hF, 1, "unmapped_wr");
    bus_rd(A_UNMAP, 32'h0, 1, "unmapped_rd2");

    // Reset asserted the cycle after a read request: no ready afterwards
    ext_irq   = '0;
    peri_rden = 1'b1;
    peri_addr = A_MTIME;
    @(posedge clk); #1;
    peri_rden = 1'b0;
    resetn    = 1'b0;
    idle(2);
    resetn = 1'b1;
    idle(3);
    bus_rd(A_MTIME, 32'h0,         1, "post_rst_mtime");
    bus_rd(A_CMP,   32'hFFFF_FFFF, 1, "post_rst_cmp");
    bus_rd(A_MASK,  32'h0,         1, "post_rst_mask");
    idle(3);
    check("scoreboard_drained", sb_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
